// File: rtl/hydra_pkg.sv
// Shared constants and FSM encoding for the port read backend.
package hydra_pkg;

  localparam int DATA_W     = 16;
  localparam int PAGE_AW    = 11;
  localparam int PAGE_WORDS = 8;
  localparam int LEN_W      = 12;
  localparam int OFF_W      = $clog2(PAGE_WORDS);
  localparam int SRAM_AW    = PAGE_AW + OFF_W;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } rd_state_e;

endpackage

// File: rtl/port_rd_page_walker.sv
// Page walker: tracks the current page/offset/remaining words of the packet
// being read, follows the link table and releases pages once fully read.
module port_rd_page_walker
  import hydra_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic [PAGE_AW-1:0] head_i,
  input  logic [LEN_W-1:0]   len_i,
  input  logic               rd_i,
  output logic [SRAM_AW-1:0] rd_addr_o,
  output logic               last_o,
  output logic               nxt_rd_en,
  output logic [PAGE_AW-1:0] nxt_rd_page,
  input  logic [PAGE_AW-1:0] nxt_page,
  output logic               page_free_vld,
  output logic [PAGE_AW-1:0] page_free_idx
);

  logic [PAGE_AW-1:0] cur_page_q, cur_page_d;
  logic [PAGE_AW-1:0] next_page_q, next_page_d;
  logic [OFF_W-1:0]   offset_q, offset_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic               nxt_pend_q, nxt_pend_d;
  logic [PAGE_AW-1:0] next_page_s;
  logic               wrap_s, last_s, head_s;

  assign last_s = (remaining_q == LEN_W'(1));
  assign wrap_s = (offset_q == OFF_W'(PAGE_WORDS - 1));
  assign head_s = (offset_q == {OFF_W{1'b0}});
  // Bypass the lookup result so a two-word page can still wrap without a bubble.
  assign next_page_s = nxt_pend_q ? nxt_page : next_page_q;

  // Next-state for the page pointer, offset and remaining-word count.
  always_comb begin
    cur_page_d  = cur_page_q;
    offset_d    = offset_q;
    remaining_d = remaining_q;
    next_page_d = next_page_s;
    nxt_pend_d  = rd_i & head_s;
    if (load_i) begin
      cur_page_d  = head_i;
      offset_d    = {OFF_W{1'b0}};
      remaining_d = (len_i == {LEN_W{1'b0}}) ? LEN_W'(1) : len_i;
    end else if (rd_i) begin
      remaining_d = remaining_q - LEN_W'(1);
      if (wrap_s && !last_s) begin
        cur_page_d = next_page_s;
        offset_d   = {OFF_W{1'b0}};
      end else begin
        offset_d = offset_q + OFF_W'(1);
      end
    end else begin
      remaining_d = remaining_q;
    end
  end

  // Walker state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_page_q  <= {PAGE_AW{1'b0}};
      next_page_q <= {PAGE_AW{1'b0}};
      offset_q    <= {OFF_W{1'b0}};
      remaining_q <= {LEN_W{1'b0}};
      nxt_pend_q  <= 1'b0;
    end else begin
      cur_page_q  <= cur_page_d;
      next_page_q <= next_page_d;
      offset_q    <= offset_d;
      remaining_q <= remaining_d;
      nxt_pend_q  <= nxt_pend_d;
    end
  end

  assign rd_addr_o     = {cur_page_q, offset_q};
  assign last_o        = last_s;
  assign nxt_rd_en     = rd_i & head_s;
  assign nxt_rd_page   = cur_page_q;
  assign page_free_vld = rd_i & (wrap_s | last_s);
  assign page_free_idx = cur_page_q;

endmodule

// File: rtl/port_rd_backend.sv
// Per-port read engine: accepts packet descriptors and streams each packet
// out of the shared SRAM page by page to the port read frontend.
module port_rd_backend
  import hydra_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pkt_req_vld,
  output logic               pkt_req_rdy,
  input  logic [PAGE_AW-1:0] pkt_head_page,
  input  logic [LEN_W-1:0]   pkt_len,
  output logic               sram_rd_en,
  output logic [SRAM_AW-1:0] sram_rd_addr,
  input  logic [DATA_W-1:0]  sram_rd_data,
  output logic               nxt_rd_en,
  output logic [PAGE_AW-1:0] nxt_rd_page,
  input  logic [PAGE_AW-1:0] nxt_page,
  output logic               page_free_vld,
  output logic [PAGE_AW-1:0] page_free_idx,
  output logic               out_ready,
  output logic               out_data_vld,
  output logic [DATA_W-1:0]  out_data,
  output logic               end_of_packet
);

  rd_state_e state_q, state_d;
  logic      rdy_q, rdy_d;
  logic      out_ready_q, out_ready_d;
  logic      out_vld_q, out_vld_d;
  logic      eop_q, eop_d;
  logic      accept_s, rd_s, last_s;

  assign accept_s = (state_q == ST_IDLE) & pkt_req_vld & rdy_q;
  assign rd_s     = (state_q == ST_STREAM);

  port_rd_page_walker u_walker (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_i        (accept_s),
    .head_i        (pkt_head_page),
    .len_i         (pkt_len),
    .rd_i          (rd_s),
    .rd_addr_o     (sram_rd_addr),
    .last_o        (last_s),
    .nxt_rd_en     (nxt_rd_en),
    .nxt_rd_page   (nxt_rd_page),
    .nxt_page      (nxt_page),
    .page_free_vld (page_free_vld),
    .page_free_idx (page_free_idx)
  );

  // FSM next state plus the one-cycle-delayed frontend strobes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_STREAM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (last_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_STREAM;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    rdy_d       = (state_d == ST_IDLE);
    out_ready_d = accept_s;
    out_vld_d   = rd_s;
    eop_d       = rd_s & last_s;
  end

  // FSM and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rdy_q       <= 1'b0;
      out_ready_q <= 1'b0;
      out_vld_q   <= 1'b0;
      eop_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= rdy_d;
      out_ready_q <= out_ready_d;
      out_vld_q   <= out_vld_d;
      eop_q       <= eop_d;
    end
  end

  assign pkt_req_rdy   = rdy_q;
  assign sram_rd_en    = rd_s;
  assign out_ready     = out_ready_q;
  assign out_data_vld  = out_vld_q;
  assign out_data      = sram_rd_data;
  assign end_of_packet = eop_q;

endmodule
